// File: rtl/rd_circ_buf_ctrl_param.sv
// Circular-buffer read controller: splits a byte-addressed read into one or two
// line-aligned NoC reads (wrapping at the buffer end) and realigns the returned lines.
module rd_circ_buf_ctrl_param #(
  parameter int DATA_W     = 512,
  parameter int BUF_ADDR_W = 16,
  parameter int SIZE_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              src_rd_buf_req_val,
  input  logic [BUF_ADDR_W-1:0]             src_rd_buf_req_addr,
  input  logic [SIZE_W-1:0]                 src_rd_buf_req_size,
  output logic                              rd_buf_src_req_rdy,
  output logic                              ctrl_rd_noc_req_val,
  output logic [BUF_ADDR_W-1:0]             ctrl_rd_noc_req_addr,
  output logic [SIZE_W-1:0]                 ctrl_rd_noc_req_size,
  input  logic                              rd_noc_ctrl_req_rdy,
  input  logic                              rd_noc_ctrl_resp_data_val,
  input  logic [DATA_W-1:0]                 rd_noc_ctrl_resp_data,
  input  logic                              rd_noc_ctrl_resp_data_last,
  output logic                              ctrl_rd_noc_resp_data_rdy,
  output logic                              rd_buf_src_resp_data_val,
  output logic [DATA_W-1:0]                 rd_buf_src_resp_data,
  output logic                              rd_buf_src_resp_data_last,
  output logic [$clog2(DATA_W/8):0]         rd_buf_src_resp_data_padbytes,
  input  logic                              src_rd_buf_resp_data_rdy
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PAD_W = OFF_W + 1;
  localparam int EW    = ((SIZE_W > BUF_ADDR_W) ? SIZE_W : BUF_ADDR_W) + 2;
  localparam logic [EW-1:0] BUF_BYTES = EW'(1) << BUF_ADDR_W;
  localparam logic [EW-1:0] LINE_MSK  = EW'(BYTES - 1);

  typedef enum logic [1:0] {READY, WRAP_REQ, STREAM, DRAIN} state_t;

  state_t              state;
  logic [OFF_W-1:0]    off_r, pad_r;
  logic [SIZE_W-1:0]   wrap_size_r, lines_left, beats_left;
  logic [DATA_W-1:0]   hold;
  logic                hold_vld;
  logic                out_val, out_last;
  logic [DATA_W-1:0]   out_data;
  logic [PAD_W-1:0]    out_pad;

  // request decode, all in EW bits so a full-buffer read cannot overflow
  logic [OFF_W-1:0]    req_off, req_pad;
  logic [EW-1:0]       req_base, req_span, req_len, req_lines, req_end, req_beats;
  logic [EW-1:0]       first_len, wrap_len;
  logic                req_wrap, req_acc;

  assign req_off   = src_rd_buf_req_addr[OFF_W-1:0];
  assign req_base  = EW'({src_rd_buf_req_addr[BUF_ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
  assign req_span  = EW'(req_off) + EW'(src_rd_buf_req_size);
  assign req_len   = (req_span + LINE_MSK) & ~LINE_MSK;
  assign req_lines = req_len >> OFF_W;
  assign req_end   = req_base + req_len;
  assign req_wrap  = req_end > BUF_BYTES;
  assign req_beats = (EW'(src_rd_buf_req_size) + LINE_MSK) >> OFF_W;
  assign req_pad   = OFF_W'(0) - src_rd_buf_req_size[OFF_W-1:0];
  assign first_len = req_wrap ? (BUF_BYTES - req_base) : req_len;
  assign wrap_len  = req_end - BUF_BYTES;
  assign req_acc   = (state == READY) && src_rd_buf_req_val && rd_noc_ctrl_req_rdy;

  // stream datapath
  logic                streaming, out_ok, use_hold, line_rdy, line_acc;
  logic                beat_mk, drain_mk, beat_now, last_beat, out_acc, done;
  logic [2*DATA_W-1:0] combo;
  logic [DATA_W-1:0]   drain_data, beat_data;
  logic [SIZE_W-1:0]   beats_after;

  assign streaming  = (state == WRAP_REQ) || (state == STREAM);
  assign out_ok     = !out_val || src_rd_buf_resp_data_rdy;
  assign use_hold   = (off_r != '0);
  assign line_rdy   = streaming && (lines_left != '0) && ((use_hold && !hold_vld) || out_ok);
  assign line_acc   = line_rdy && rd_noc_ctrl_resp_data_val;
  assign beat_mk    = line_acc && (!use_hold || hold_vld) && (beats_left != '0);
  assign drain_mk   = (state == DRAIN) && (beats_left != '0) && out_ok;
  assign beat_now   = beat_mk || drain_mk;
  assign last_beat  = (beats_left == SIZE_W'(1));
  assign out_acc    = out_val && src_rd_buf_resp_data_rdy;
  assign done       = out_acc && out_last;
  assign beats_after = beats_left - SIZE_W'(beat_mk);

  assign combo      = {rd_noc_ctrl_resp_data, hold} >> {off_r, 3'b000};
  assign drain_data = hold >> {off_r, 3'b000};
  assign beat_data  = drain_mk ? drain_data : (use_hold ? combo[DATA_W-1:0] : rd_noc_ctrl_resp_data);

  // request-side handshakes are combinational pass-throughs in READY
  assign rd_buf_src_req_rdy  = !rst && (state == READY) && rd_noc_ctrl_req_rdy;
  assign ctrl_rd_noc_req_val = !rst && ((state == READY) ? src_rd_buf_req_val : (state == WRAP_REQ));
  assign ctrl_rd_noc_req_addr = (state == READY) ? req_base[BUF_ADDR_W-1:0] : '0;
  assign ctrl_rd_noc_req_size = (state == READY)    ? first_len[SIZE_W-1:0] :
                                (state == WRAP_REQ) ? wrap_size_r : '0;
  assign ctrl_rd_noc_resp_data_rdy = !rst && line_rdy;

  assign rd_buf_src_resp_data_val      = out_val;
  assign rd_buf_src_resp_data          = out_data;
  assign rd_buf_src_resp_data_last     = out_last;
  assign rd_buf_src_resp_data_padbytes = out_pad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= READY;
      off_r       <= '0;
      pad_r       <= '0;
      wrap_size_r <= '0;
      lines_left  <= '0;
      beats_left  <= '0;
      hold        <= '0;
      hold_vld    <= 1'b0;
      out_val     <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_pad     <= '0;
    end else begin
      if (out_acc) out_val <= 1'b0;
      if (beat_now) begin
        out_val    <= 1'b1;
        out_data   <= beat_data;
        out_last   <= last_beat;
        out_pad    <= last_beat ? {1'b0, pad_r} : '0;
        beats_left <= beats_left - SIZE_W'(1);
      end
      if (line_acc) begin
        lines_left <= lines_left - SIZE_W'(1);
        if (use_hold) begin
          hold     <= rd_noc_ctrl_resp_data;
          hold_vld <= 1'b1;
        end
      end
      case (state)
        READY: if (req_acc) begin
          off_r       <= req_off;
          pad_r       <= req_pad;
          wrap_size_r <= wrap_len[SIZE_W-1:0];
          lines_left  <= req_lines[SIZE_W-1:0];
          beats_left  <= req_beats[SIZE_W-1:0];
          hold_vld    <= 1'b0;
          state       <= req_wrap ? WRAP_REQ : STREAM;
        end
        WRAP_REQ: if (rd_noc_ctrl_req_rdy) state <= STREAM;
        STREAM: begin
          if (done) begin
            state    <= READY;
            hold_vld <= 1'b0;
          end else if (line_acc && (lines_left == SIZE_W'(1)) && (beats_after != '0))
            // last line fed the hold register but one beat still needs its tail bytes
            state <= DRAIN;
        end
        DRAIN: if (done) begin
          state    <= READY;
          hold_vld <= 1'b0;
        end
        default: state <= READY;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst && req_acc)
      assert (src_rd_buf_req_size != '0 && EW'(src_rd_buf_req_size) <= BUF_BYTES);
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, rd_noc_ctrl_resp_data_last, combo[2*DATA_W-1:DATA_W],
                       req_lines[EW-1:SIZE_W], req_beats[EW-1:SIZE_W],
                       first_len[EW-1:SIZE_W], wrap_len[EW-1:SIZE_W], req_base[EW-1:BUF_ADDR_W]};
endmodule
